// File: rtl/led_pattern_sequencer.sv
// LED pattern sequencer: decodes key-press-count commands into display patterns
// and steps the LED bank on a programmable tick.
module led_pattern_sequencer #(
  parameter int unsigned LED_W    = 8,
  parameter int unsigned TICK_DIV = 50_000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  input  logic [2:0]       cmd_count,
  output logic [LED_W-1:0] led,
  output logic [2:0]       mode,
  output logic             paused,
  output logic             fast
);

  localparam int unsigned CntW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CntW-1:0] LastSlow = CntW'(TICK_DIV - 1);
  localparam logic [CntW-1:0] LastFast = CntW'(TICK_DIV / 4 - 1);

  localparam logic [2:0] ModeOff   = 3'd1;
  localparam logic [2:0] ModeShl   = 3'd2;
  localparam logic [2:0] ModeShr   = 3'd3;
  localparam logic [2:0] ModeBlink = 3'd4;
  localparam logic [2:0] ModePing  = 3'd5;

  localparam logic [LED_W-1:0] LedLsb = {{(LED_W-1){1'b0}}, 1'b1};
  localparam logic [LED_W-1:0] LedMsb = {1'b1, {(LED_W-1){1'b0}}};

  typedef enum logic [1:0] {StOff, StRun, StPause} state_e;

  state_e          state;
  logic [CntW-1:0] tick_cnt;
  logic            dir_left;

  logic             cmd_act;
  logic             tick_wrap;
  logic [LED_W-1:0] led_step;
  logic             dir_step;
  logic [LED_W-1:0] led_init;

  assign cmd_act   = cmd_valid && (cmd_count != 3'd0);
  assign tick_wrap = (state == StRun) && (tick_cnt == (fast ? LastFast : LastSlow));

  // Next LED value for one pattern step in the current mode.
  always_comb begin
    led_step = led;
    dir_step = dir_left;
    case (mode)
      ModeShl:   led_step = {led[LED_W-2:0], led[LED_W-1]};
      ModeShr:   led_step = {led[0], led[LED_W-1:1]};
      ModeBlink: led_step = ~led;
      ModePing: begin
        if (dir_left) begin
          led_step = led << 1;
          if (led[LED_W-2]) dir_step = 1'b0;
        end else begin
          led_step = led >> 1;
          if (led[1]) dir_step = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    case (cmd_count)
      3'd3:    led_init = LedMsb;
      3'd4:    led_init = '1;
      default: led_init = LedLsb;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= StOff;
      led      <= '0;
      mode     <= ModeOff;
      paused   <= 1'b0;
      fast     <= 1'b0;
      tick_cnt <= '0;
      dir_left <= 1'b1;
    end else if (cmd_act) begin
      // A command always wins over a coincident tick wrap; that step is dropped.
      case (cmd_count)
        3'd1: begin
          state    <= StOff;
          led      <= '0;
          mode     <= ModeOff;
          paused   <= 1'b0;
          tick_cnt <= '0;
        end
        3'd2, 3'd3, 3'd4, 3'd5: begin
          state    <= StRun;
          led      <= led_init;
          mode     <= cmd_count;
          paused   <= 1'b0;
          tick_cnt <= '0;
          dir_left <= 1'b1;
        end
        3'd6: begin
          if (state == StRun) begin
            state  <= StPause;
            paused <= 1'b1;
          end else if (state == StPause) begin
            state  <= StRun;
            paused <= 1'b0;
          end
        end
        3'd7: begin
          fast     <= ~fast;
          tick_cnt <= '0;
        end
        default: ;
      endcase
    end else if (state == StRun) begin
      if (tick_wrap) begin
        tick_cnt <= '0;
        led      <= led_step;
        dir_left <= dir_step;
      end else begin
        tick_cnt <= tick_cnt + 1'b1;
      end
    end
  end

endmodule
